// File: rtl/key_step_ctrl_pkg.sv
// Shared types and constants for the push-button step front end.
// The key index constants are reused by the delay controller wiring.
package key_step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2,
        LOCK      = 2'd3
    } step_state_e;

    localparam int unsigned KEY_SLOWER = 0;
    localparam int unsigned KEY_FASTER = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must hold every value from 0 up to max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_step_ctrl_debounce.sv
// Two-flop synchroniser and debounce counter for one active-low push button.
// The output only follows the button after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce
    import key_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             raw;

    assign raw     = ~sync2_q;
    assign pressed = pressed_q;

    // Any sample agreeing with the accepted level restarts the count, so short glitches die out.
    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        cnt_d     = '0;
        pressed_d = pressed_q;
        if (raw != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = raw;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
        end
    end

endmodule

// File: rtl/key_step_ctrl.sv
// Turns the faster/slower push buttons into single-cycle step commands with
// auto-repeat while held; pressing both keys locks stepping until both are released.
module key_step_ctrl
    import key_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] key_n,
    output logic [1:0] step,
    output logic [1:0] pressed
);

    localparam int unsigned RPT_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);

    if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_repeat
        $error("key_step_ctrl: REPEAT_DELAY and REPEAT_RATE must be >= 2");
    end

    logic [1:0]       pressed_w;
    step_state_e      state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             active_q, active_d;
    logic [1:0]       step_q, step_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_faster (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n[KEY_FASTER]),
        .pressed(pressed_w[KEY_FASTER])
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_slower (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n[KEY_SLOWER]),
        .pressed(pressed_w[KEY_SLOWER])
    );

    assign pressed = pressed_w;
    assign step    = step_q;

    // Exit priority while holding: release first, then the other key (lock), then repeat expiry.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        active_d  = active_q;
        step_d    = 2'b00;
        case (state_q)
            IDLE: begin
                if (pressed_w == 2'b11) begin
                    state_d = LOCK;
                end else if (pressed_w != 2'b00) begin
                    step_d    = pressed_w;
                    active_d  = pressed_w[KEY_FASTER];
                    rpt_cnt_d = DELAY_LOAD;
                    state_d   = HOLD_WAIT;
                end
            end
            HOLD_WAIT, REPEAT: begin
                if (!pressed_w[active_q]) begin
                    state_d = IDLE;
                end else if (pressed_w[~active_q]) begin
                    state_d = LOCK;
                end else if (rpt_cnt_q == '0) begin
                    step_d[active_q] = 1'b1;
                    rpt_cnt_d        = RATE_LOAD;
                    state_d          = REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
                end
            end
            LOCK: begin
                if (pressed_w == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
            active_q  <= 1'b0;
            step_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            active_q  <= active_d;
            step_q    <= step_d;
        end
    end

    step_never_both: assert property (@(posedge clk) disable iff (reset) step_q != 2'b11);

endmodule
